// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: default widths, program entry points
// and the sequencer state encoding.
package fetch_pkg;

  localparam int unsigned PcW      = 11;
  localparam int unsigned OffW     = 8;
  localparam int unsigned NumProgs = 3;

  // Program i lives at slice [i*PcW +: PcW].
  localparam logic [NumProgs*PcW-1:0] DefaultProgBase = {11'd512, 11'd256, 11'd0};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for call/return; dout always presents the current top.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  top_ptr;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_ptr = cnt_q - CntW'(1);
  assign dout    = empty ? '0 : mem_q[top_ptr[IdxW-1:0]];

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem_q[cnt_q[IdxW-1:0]] <= din;
      cnt_q                  <= cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: program select, relative/absolute branches,
// call/return via ret_stack, and a run/halt state machine.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned                 PC_W        = PcW,
  parameter int unsigned                 OFF_W       = OffW,
  parameter int unsigned                 NUM_PROGS   = NumProgs,
  parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASE   = DefaultProgBase,
  parameter int unsigned                 STACK_DEPTH = 4,
  parameter int unsigned                 PSEL_W      = sel_width(NUM_PROGS)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [PSEL_W-1:0]       ProgSel,
  input  logic                    BranchRelEn,
  input  logic                    ALU_flag,
  input  logic signed [OFF_W-1:0] Target,
  input  logic                    BranchAbsEn,
  input  logic [PC_W-1:0]         AbsTarget,
  input  logic                    CallEn,
  input  logic                    RetEn,
  input  logic                    HaltEn,
  output logic [PC_W-1:0]         ProgCtr,
  output logic                    Running,
  output logic                    Done,
  output logic                    StackErr
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] base, pc_inc, rel_ext, stk_top;
  logic            err_q, err_d;
  logic            running_q, done_q;
  logic            push, pop, clear, full, empty;

  assign pc_inc  = pc_q + PC_W'(1);
  assign rel_ext = PC_W'(Target);

  // Out-of-range selects fall back to program 0.
  always_comb begin
    base = PROG_BASE[0 +: PC_W];
    for (int i = 1; i < int'(NUM_PROGS); i++) begin
      if (ProgSel == PSEL_W'(i)) base = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;

    if (Start) begin
      state_d = StHold;
      pc_d    = base;
      err_d   = 1'b0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHold: state_d = StRun;
        StDone: ;
        StRun: begin
          if (HaltEn) begin
            state_d = StDone;
          end else if (RetEn) begin
            if (!empty) begin
              pc_d = stk_top;
              pop  = 1'b1;
            end else begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end
          end else if (CallEn) begin
            if (!full) begin
              pc_d = AbsTarget;
              push = 1'b1;
            end else begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end
          end else if (BranchAbsEn) begin
            pc_d = AbsTarget;
          end else if (BranchRelEn && ALU_flag) begin
            pc_d = pc_q + rel_ext;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (full),
    .empty (empty)
  );

  assign ProgCtr  = pc_q;
  assign Running  = running_q;
  assign Done     = done_q;
  assign StackErr = err_q;

endmodule
